data_mem_access: RTL

Multi-cycle data-memory access unit for the MEM stage of the pipelined core. It accepts one load or store per instruction from the EX/MEM register and runs a valid/ready request with an acknowledge response on the SoC data bus. It stalls the pipeline until the access completes, then presents the raw 32-bit read word together with its byte offset, size and signedness to the load-alignment logic. Store data replication, byte-strobe generation, misalignment detection and a bus timeout are all handled here.

---
 rtl/data_mem_access_pkg.sv | 25 ++
 rtl/data_mem_access_if.sv | 21 ++
 rtl/data_mem_access_store_align.sv | 29 ++
 rtl/data_mem_access.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/data_mem_access_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access unit.
package data_mem_access_pkg;

  localparam logic [1:0] DT_BYTE = 2'd0;
  localparam logic [1:0] DT_HALF = 2'd1;
  localparam logic [1:0] DT_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  // DataType 3 is not a legal size and is reported the same way as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] dtype, input logic [1:0] off);
    case (dtype)
      DT_BYTE: return 1'b0;
      DT_HALF: return off[0];
      DT_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_access_if.sv
// SoC data-bus signals: valid/ready request channel plus acknowledge response.
interface data_mem_access_if;
  logic        BusValid;
  logic        BusReady;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic [3:0]  BusWStrb;
  logic        BusAck;
  logic [31:0] BusRData;

  modport master (
    output BusValid, BusWe, BusAddr, BusWData, BusWStrb,
    input  BusReady, BusAck, BusRData
  );

  modport slave (
    input  BusValid, BusWe, BusAddr, BusWData, BusWStrb,
    output BusReady, BusAck, BusRData
  );
endinterface

// File: rtl/data_mem_access_store_align.sv
// Byte-strobe generation and store-data lane replication for sub-word stores.
module store_align
  import data_mem_access_pkg::*;
(
  input  logic [1:0]  dtype_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [3:0]  strb_o,
  output logic [31:0] data_o
);

  always_comb begin
    strb_o = '0;
    data_o = data_i;
    case (dtype_i)
      DT_BYTE: begin
        strb_o = 4'b0001 << offset_i;
        data_o = {4{data_i[7:0]}};
      end
      DT_HALF: begin
        strb_o = 4'b0011 << offset_i;
        data_o = {2{data_i[15:0]}};
      end
      DT_WORD: strb_o = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// MEM-stage load/store unit: stalls the pipeline while one bus access runs
// through REQ/WAIT, then presents the raw read word and its load metadata.
module data_mem_access
  import data_mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Flush,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  input  logic [1:0]  DataType,
  input  logic        Unsigned,
  output logic        Stall,
  output logic        MisalignErr,
  output logic        BusErr,
  output logic        LoadValid,
  output logic [31:0] LoadData,
  output logic [1:0]  LoadOffset,
  output logic [1:0]  LoadType,
  output logic        LoadUnsigned,
  data_mem_access_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strb_q, strb_d;
  logic [31:0]   ldata_q, ldata_d;
  logic [1:0]    loff_q, loff_d;
  logic [1:0]    ltype_q, ltype_d;
  logic          luns_q, luns_d;
  logic          lvalid_q, lvalid_d;
  logic          berr_q, berr_d;

  logic          req;
  logic          misaligned;
  logic [3:0]    sa_strb;
  logic [31:0]   sa_data;

  assign req        = (MemRead | MemWrite) & ~Flush;
  assign misaligned = is_misaligned(DataType, Addr[1:0]);

  store_align u_store_align (
    .dtype_i  (DataType),
    .offset_i (Addr[1:0]),
    .data_i   (StoreData),
    .strb_o   (sa_strb),
    .data_o   (sa_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    ldata_d     = ldata_q;
    loff_d      = loff_q;
    ltype_d     = ltype_q;
    luns_d      = luns_q;
    lvalid_d    = 1'b0;
    berr_d      = 1'b0;
    Stall       = 1'b0;
    MisalignErr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req && misaligned) begin
          MisalignErr = 1'b1;
        end else if (req) begin
          Stall   = 1'b1;
          valid_d = 1'b1;
          we_d    = MemWrite;
          addr_d  = {Addr[31:2], 2'b00};
          wdata_d = MemWrite ? sa_data : '0;
          strb_d  = MemWrite ? sa_strb : '0;
          loff_d  = Addr[1:0];
          ltype_d = DataType;
          luns_d  = Unsigned;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        Stall = 1'b1;
        if (bus.BusReady) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        Stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        // An acknowledge in the final counted cycle still completes normally.
        if (bus.BusAck) begin
          if (!we_q) begin
            ldata_d  = bus.BusRData;
            lvalid_d = 1'b1;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          berr_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      ldata_q  <= '0;
      loff_q   <= '0;
      ltype_q  <= '0;
      luns_q   <= 1'b0;
      lvalid_q <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      ldata_q  <= ldata_d;
      loff_q   <= loff_d;
      ltype_q  <= ltype_d;
      luns_q   <= luns_d;
      lvalid_q <= lvalid_d;
      berr_q   <= berr_d;
    end
  end

  assign bus.BusValid  = valid_q;
  assign bus.BusWe     = we_q;
  assign bus.BusAddr   = addr_q;
  assign bus.BusWData  = wdata_q;
  assign bus.BusWStrb  = strb_q;
  assign LoadValid     = lvalid_q;
  assign BusErr        = berr_q;
  assign LoadData      = ldata_q;
  assign LoadOffset    = loff_q;
  assign LoadType      = ltype_q;
  assign LoadUnsigned  = luns_q;

endmodule
